packet_sink: RTL and testbench

- Downstream consumer of the packet source.
- Receives flits over a two-phase (toggle) req/ack link and frames them into packets using the head bit (data MSB).
- Assembles FLITS flits into one wide word and presents it on a valid/ready port to the local endpoint.
- Counts delivered packets and dropped flits, and flags framing errors.

---
 rtl/packet_sink_pkg.sv | 20 ++
 rtl/packet_sink_toggle_rx.sv | 56 +++++
 rtl/packet_sink.sv | 151 +++++++++++++++
 tb/tb_packet_sink.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_sink_pkg.sv
// Shared definitions for the packet sink: default geometry, framing states and sizing helpers.
package packet_sink_pkg;

    localparam int unsigned DEF_FLITS    = 8;
    localparam int unsigned DEF_SIZE     = 8;
    localparam int unsigned DEF_CNT_BITS = 16;
    localparam int unsigned DROP_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    // Index width for a flit counter covering 0..flits-1 (at least one bit).
    function automatic int unsigned idx_bits(input int unsigned flits);
        return (flits <= 2) ? 1 : $clog2(flits);
    endfunction

endpackage

// File: rtl/packet_sink_toggle_rx.sv
// Two-phase (toggle) req/ack receiver: pending detect, ack toggle on consume.
// PACKET_SINK_REQ_SYNC_EN adds a two-flop synchroniser on req for a foreign clock domain.
module packet_sink_toggle_rx (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic consume,
    output logic pending_c,
    output logic ack
);

    logic req_s;
    logic req_old_q, req_old_d;
    logic ack_q, ack_d;

`ifdef PACKET_SINK_REQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], req};
        end
    end

    assign req_s = sync_q[1];
`else
    assign req_s = req;
`endif

    assign pending_c = req_s ^ req_old_q;

    // A flit is taken only when the consumer asks and one is actually outstanding.
    always_comb begin
        req_old_d = req_old_q;
        ack_d     = ack_q;
        if (consume && pending_c) begin
            req_old_d = req_s;
            ack_d     = ~ack_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_old_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            req_old_q <= req_old_d;
            ack_q     <= ack_d;
        end
    end

    assign ack = ack_q;

endmodule

// File: rtl/packet_sink.sv
// Packet sink: frames toggle-link flits into FLITS-flit packets and hands them to a valid/ready endpoint.
// Optional macro PACKET_SINK_REQ_SYNC_EN synchronises req inside the toggle receiver.
module packet_sink
    import packet_sink_pkg::*;
#(
    parameter int unsigned ID       = 0,
    parameter int unsigned FLITS    = DEF_FLITS,
    parameter int unsigned SIZE     = DEF_SIZE,
    parameter int unsigned CNT_BITS = DEF_CNT_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    output logic                  ack,
    input  logic [SIZE-1:0]       data,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [FLITS*SIZE-1:0] pkt_data,
    output logic [CNT_BITS-1:0]   pkt_count,
    output logic [DROP_BITS-1:0]  drop_count,
    output logic                  err_framing
);

    localparam int unsigned IDX_W = idx_bits(FLITS);
    localparam int unsigned PW    = FLITS * SIZE;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            flit_idx_q, flit_idx_d;
    logic [FLITS-1:0][SIZE-1:0]  flit_buf_q, flit_buf_d;
    logic                        pkt_valid_q, pkt_valid_d;
    logic [PW-1:0]               pkt_data_q, pkt_data_d;
    logic [CNT_BITS-1:0]         pkt_count_q, pkt_count_d;
    logic [DROP_BITS-1:0]        drop_count_q, drop_count_d;
    logic                        err_q, err_d;

    logic pending_c;
    logic consume_c;
    logic head_c;
    logic last_c;

    // Flits are left waiting in HOLD so the withheld ack backpressures the source.
    assign consume_c = pending_c && (state_q != ST_HOLD);
    assign head_c    = data[SIZE-1];
    assign last_c    = (flit_idx_q == IDX_W'(FLITS - 1));

    packet_sink_toggle_rx u_toggle_rx (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .consume   (consume_c),
        .pending_c (pending_c),
        .ack       (ack)
    );

    always_comb begin
        state_d      = state_q;
        flit_idx_d   = flit_idx_q;
        flit_buf_d   = flit_buf_q;
        pkt_valid_d  = pkt_valid_q;
        pkt_data_d   = pkt_data_q;
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_c) begin
                    if (head_c) begin
                        flit_buf_d[0] = data;
                        flit_idx_d    = IDX_W'(1);
                        state_d       = ST_COLLECT;
                    end else if (drop_count_q != '1) begin
                        drop_count_d = drop_count_q + DROP_BITS'(1);
                    end
                end
            end

            ST_COLLECT: begin
                if (pending_c) begin
                    if (head_c) begin
                        // A new head restarts the packet; the partial one is lost.
                        err_d         = 1'b1;
                        flit_buf_d[0] = data;
                        flit_idx_d    = IDX_W'(1);
                    end else if (last_c) begin
                        pkt_data_d  = {data, flit_buf_q[FLITS-2:0]};
                        pkt_valid_d = 1'b1;
                        flit_idx_d  = '0;
                        state_d     = ST_HOLD;
                    end else begin
                        for (int i = 0; i < int'(FLITS); i++) begin
                            if (IDX_W'(i) == flit_idx_q) begin
                                flit_buf_d[i] = data;
                            end
                        end
                        flit_idx_d = flit_idx_q + IDX_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (pkt_valid_q && pkt_ready) begin
                    pkt_valid_d = 1'b0;
                    pkt_count_d = pkt_count_q + CNT_BITS'(1);
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            flit_idx_q   <= '0;
            flit_buf_q   <= '0;
            pkt_valid_q  <= 1'b0;
            pkt_data_q   <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flit_idx_q   <= flit_idx_d;
            flit_buf_q   <= flit_buf_d;
            pkt_valid_q  <= pkt_valid_d;
            pkt_data_q   <= pkt_data_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            err_q        <= err_d;
        end
    end

    // Debug guard: a presented packet must always coincide with the HOLD state.
    always @(posedge clk) begin
        if (reset && pkt_valid_q) begin
            assert (state_q == ST_HOLD)
                else $error("packet_sink[%0d]: pkt_valid outside HOLD", ID);
        end
    end

    assign pkt_valid   = pkt_valid_q;
    assign pkt_data    = pkt_data_q;
    assign pkt_count   = pkt_count_q;
    assign drop_count  = drop_count_q;
    assign err_framing = err_q;

endmodule

// File: tb/tb_packet_sink.sv
// Self-checking bench for packet_sink: directed scenarios plus a randomized flit stream
// checked against a queue-based framing model.
module tb_packet_sink;

    localparam int unsigned FLITS    = 8;
    localparam int unsigned SIZE     = 8;
    localparam int unsigned CNT_BITS = 16;
    localparam int unsigned PW       = FLITS * SIZE;
`ifdef PACKET_SINK_REQ_SYNC_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 1;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                req;
    logic                ack;
    logic [SIZE-1:0]     data;
    logic                pkt_valid;
    logic                pkt_ready;
    logic [PW-1:0]       pkt_data;
    logic [CNT_BITS-1:0] pkt_count;
    logic [7:0]          drop_count;
    logic                err_framing;

    logic ready_main = 1'b1;
    logic rnd_mode   = 1'b0;
    logic rnd_ready  = 1'b1;
    assign pkt_ready = rnd_mode ? rnd_ready : ready_main;

    int checks = 0;
    int errors = 0;

    packet_sink #(.ID(0), .FLITS(FLITS), .SIZE(SIZE), .CNT_BITS(CNT_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .data        (data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_data    (pkt_data),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count),
        .err_framing (err_framing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: delivered packets, ack toggles, pkt_data stability while held.
    logic [PW-1:0] got_q[$];
    int            ack_toggles = 0;
    int            stab_viol   = 0;
    logic          ack_prev    = 1'b0;
    logic          vprev       = 1'b0;
    logic [PW-1:0] dprev       = '0;

    always @(negedge clk) begin
        if (ack !== ack_prev) ack_toggles++;
        ack_prev = ack;
        if (pkt_valid && vprev && (pkt_data !== dprev)) stab_viol++;
        if (pkt_valid && pkt_ready) got_q.push_back(pkt_data);
        vprev = pkt_valid && !pkt_ready;
        dprev = pkt_data;
    end

    // Reference model: packets are a head flit followed by FLITS-1 body flits.
    logic [SIZE-1:0] m_cur[$];
    logic [PW-1:0]   exp_q[$];
    int              m_drop   = 0;
    int              m_pkts   = 0;
    bit              m_err    = 0;
    int              got_base = 0;

    function automatic void model_flit(input logic [SIZE-1:0] d);
        logic [PW-1:0] pk;
        if (d[SIZE-1]) begin
            if (m_cur.size() != 0) m_err = 1;
            m_cur.delete();
            m_cur.push_back(d);
        end else if (m_cur.size() == 0) begin
            if (m_drop < 255) m_drop++;
        end else begin
            m_cur.push_back(d);
            if (m_cur.size() == FLITS) begin
                pk = '0;
                for (int i = 0; i < int'(FLITS); i++) pk[i*SIZE +: SIZE] = m_cur[i];
                exp_q.push_back(pk);
                m_pkts++;
                m_cur.delete();
            end
        end
    endfunction

    function automatic void model_reset();
        m_cur.delete();
        exp_q.delete();
        m_drop   = 0;
        m_pkts   = 0;
        m_err    = 0;
        got_base = got_q.size();
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        req   = 1'b0;
        data  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic send_flit(input logic [SIZE-1:0] d, output int lat);
        bit ok;
        data = d;
        req  = ~req;
        lat  = 0;
        ok   = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack === req) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_flit_timeout: ack=%b req=%b flit=%h", ack, req, d);
        end else begin
            model_flit(d);
        end
    endtask

    task automatic send_pkt(input logic [PW-1:0] p);
        int lat;
        for (int i = 0; i < int'(FLITS); i++) send_flit(p[i*SIZE +: SIZE], lat);
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] p;
        for (int i = 0; i < int'(FLITS); i++) p[i*SIZE +: SIZE] = SIZE'($urandom_range(0, 127));
        p[SIZE-1] = 1'b1;
        return p;
    endfunction

    task automatic drain(output bit ok);
        ok = 0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if ((got_q.size() - got_base) == exp_q.size() && !pkt_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack, pkt_valid, err_framing} !== 3'b000 || pkt_data !== '0 ||
            pkt_count !== '0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: ack=%b valid=%b err=%b data=%h cnt=%0d drop=%0d want all zero",
                     ack, pkt_valid, err_framing, pkt_data, pkt_count, drop_count);
        end
    endtask

    task automatic test_single();
        logic [SIZE-1:0] fl[FLITS] = '{8'h85, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        int lat;
        int t0;
        do_reset();
        ready_main = 1'b1;
        t0 = ack_toggles;
        for (int i = 0; i < int'(FLITS); i++) begin
            send_flit(fl[i], lat);
            checks++;
            if (lat != EXP_LAT) begin
                errors++;
                $display("FAIL single_ack_latency: flit %0d latency %0d want %0d", i, lat, EXP_LAT);
            end
        end
        checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== 64'h7766554433221185) begin
            errors++;
            $display("FAIL single_pkt: valid=%b data=%h want 1 7766554433221185", pkt_valid, pkt_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pkt_valid !== 1'b0 || pkt_count !== 16'd1 || (ack_toggles - t0) != 8) begin
            errors++;
            $display("FAIL single_after: valid=%b count=%0d acks=%0d want 0 1 8",
                     pkt_valid, pkt_count, ack_toggles - t0);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] a, b;
        int lat;
        int t0;
        bit ok;
        do_reset();
        a = rand_pkt();
        b = rand_pkt();
        ready_main = 1'b0;
        t0 = ack_toggles;
        send_pkt(a);
        data = b[SIZE-1:0];
        req  = ~req;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (ack === req || (ack_toggles - t0) != 8 || pkt_valid !== 1'b1 || pkt_data !== a) begin
            errors++;
            $display("FAIL bp_hold: ack=%b req=%b acks=%0d valid=%b data=%h want frozen 8 1 %h",
                     ack, req, ack_toggles - t0, pkt_valid, pkt_data, a);
        end
        ready_main = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pkt_valid !== 1'b0 || pkt_count !== 16'd1 || ack === req) begin
            errors++;
            $display("FAIL bp_handshake: valid=%b count=%0d ack_done=%b want 0 1 0",
                     pkt_valid, pkt_count, ack === req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ack !== req) begin
            errors++;
            $display("FAIL bp_resume: ack=%b req=%b want equal", ack, req);
        end
        model_flit(b[SIZE-1:0]);
        for (int i = 1; i < int'(FLITS); i++) send_flit(b[i*SIZE +: SIZE], lat);
        drain(ok);
        checks++;
        if (!ok || pkt_count !== 16'd2 || got_q[got_base+1] !== b || got_q[got_base] !== a) begin
            errors++;
            $display("FAIL bp_packets: drained=%b count=%0d last=%h want 1 2 %h", ok, pkt_count,
                     got_q[got_q.size()-1], b);
        end
    endtask

    task automatic test_junk();
        logic [PW-1:0] p;
        int lat;
        bit ok;
        do_reset();
        ready_main = 1'b1;
        send_flit(8'h01, lat);
        send_flit(8'h02, lat);
        send_flit(8'h03, lat);
        p = rand_pkt();
        send_pkt(p);
        drain(ok);
        checks++;
        if (!ok || drop_count !== 8'd3 || pkt_count !== 16'd1 || got_q[got_base] !== p) begin
            errors++;
            $display("FAIL junk_lead: drained=%b drop=%0d count=%0d got=%h want 1 3 1 %h",
                     ok, drop_count, pkt_count, got_q[got_q.size()-1], p);
        end
        for (int i = 0; i < 300; i++) send_flit(SIZE'($urandom_range(0, 127)), lat);
        checks++;
        if (drop_count !== 8'd255 || m_drop != 255) begin
            errors++;
            $display("FAIL junk_saturate: drop=%0d want 255", drop_count);
        end
    endtask

    task automatic test_framing();
        int lat;
        bit ok;
        do_reset();
        ready_main = 1'b1;
        send_flit(8'h80, lat);
        send_flit(8'h01, lat);
        send_flit(8'h02, lat);
        send_flit(8'h9A, lat);
        for (int i = 0; i < int'(FLITS) - 1; i++) send_flit(SIZE'(8'h10 + i), lat);
        drain(ok);
        checks++;
        if (!ok || err_framing !== 1'b1 || pkt_count !== 16'd1 || got_q[got_base][7:0] !== 8'h9A ||
            got_q[got_base] !== exp_q[0]) begin
            errors++;
            $display("FAIL framing: drained=%b err=%b count=%0d got=%h want 1 1 1 %h",
                     ok, err_framing, pkt_count, got_q[got_q.size()-1], exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] p;
        int lat;
        bit ok;
        do_reset();
        ready_main = 1'b1;
        send_flit(8'h05, lat);
        send_flit(8'hC1, lat);
        for (int i = 0; i < 3; i++) send_flit(SIZE'(8'h21 + i), lat);
        #3;
        reset = 1'b0;
        req   = 1'b0;
        #1;
        checks++;
        if ({ack, pkt_valid, err_framing} !== 3'b000 || pkt_data !== '0 ||
            pkt_count !== '0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: ack=%b valid=%b err=%b cnt=%0d drop=%0d want all zero",
                     ack, pkt_valid, err_framing, pkt_count, drop_count);
        end
        do_reset();
        p = rand_pkt();
        send_pkt(p);
        drain(ok);
        checks++;
        if (!ok || pkt_count !== 16'd1 || got_q[got_base] !== p || err_framing !== 1'b0) begin
            errors++;
            $display("FAIL reset_resend: drained=%b count=%0d err=%b got=%h want 1 1 0 %h",
                     ok, pkt_count, err_framing, got_q[got_q.size()-1], p);
        end
    endtask

    task automatic test_random();
        int lat;
        int k;
        bit ok;
        bit same;
        do_reset();
        rnd_mode = 1'b1;
        for (int ev = 0; ev < 30; ev++) begin
            k = int'($urandom_range(0, 9));
            if (k == 0) begin
                send_flit(SIZE'($urandom_range(0, 127)), lat);
            end else if (k == 1) begin
                send_flit(SIZE'($urandom_range(128, 255)), lat);
                for (int j = 0; j < int'($urandom_range(0, FLITS - 2)); j++)
                    send_flit(SIZE'($urandom_range(0, 127)), lat);
            end else begin
                send_pkt(rand_pkt());
            end
        end
        drain(ok);
        rnd_mode = 1'b0;
        same = ok;
        for (int i = 0; ok && i < exp_q.size(); i++) begin
            if (got_q[got_base+i] !== exp_q[i] || got_q[got_base+i][SIZE-1] !== 1'b1) same = 0;
        end
        checks++;
        if (!same) begin
            errors++;
            $display("FAIL random_packets: drained=%b got %0d want %0d packets or data differs",
                     ok, got_q.size() - got_base, exp_q.size());
        end
        checks++;
        if (pkt_count !== CNT_BITS'(m_pkts) || drop_count !== 8'(m_drop) || err_framing !== m_err) begin
            errors++;
            $display("FAIL random_counters: count=%0d drop=%0d err=%b want %0d %0d %b",
                     pkt_count, drop_count, err_framing, m_pkts, m_drop, m_err);
        end
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL pkt_data_stable: %0d changes while valid, want 0", stab_viol);
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = 1'b0;
        data  = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_junk();
        test_framing();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
